// File: rtl/irq_pkg.sv
// Shared types and default sizing for the interrupt scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package irq_pkg;

    localparam int          NUM_SRC_DEF     = 4;
    localparam logic [31:0] ISR_STRIDE_DEF  = 32'h20;
    localparam int          ACK_TIMEOUT_DEF = 15;

    // Source id width; the active_id port is fixed at 2 bits.
    localparam int          ID_W            = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;

endpackage

// File: rtl/irq_arb.sv
// Picks one source from pending & ~mask, searching upward from last_id+1 (mod NUM_SRC).
// Latency: purely combinational.
// Backpressure: none; the caller decides when to act on valid/id.
module irq_arb
    import irq_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF
) (
    input  logic [NUM_SRC-1:0] pending,
    input  logic [NUM_SRC-1:0] mask,
    input  logic [ID_W-1:0]    last_id,
    output logic               valid,
    output logic [ID_W-1:0]    id
);

    logic [NUM_SRC-1:0] cand;

    assign cand = pending & ~mask;

    // Scan from the farthest offset down to the nearest so the source closest
    // after last_id is the one left standing.
    always_comb begin
        int idx;
        valid = 1'b0;
        id    = '0;
        idx   = 0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            idx = (int'(last_id) + k) % NUM_SRC;
            if (cand[idx[ID_W-1:0]]) begin
                valid = 1'b1;
                id    = idx[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/irq_scheduler.sv
// Latches request edges, arbitrates, and hands one interrupt at a time to the MIPS core (IDLE/REQ/SERVICE).
// Latency: req edge -> pending 1 cycle, pending -> irq 1 cycle; isr_done -> next irq 2 cycles.
// Backpressure: irq held until irq_ack or ACK_TIMEOUT cycles; IRQ_ROUND_ROBIN_EN selects round-robin over fixed priority.
module irq_scheduler
    import irq_pkg::*;
#(
    parameter int          NUM_SRC     = NUM_SRC_DEF,
    parameter logic [31:0] ISR_STRIDE  = ISR_STRIDE_DEF,
    parameter int          ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] req,
    input  logic [NUM_SRC-1:0] mask,
    input  logic               irq_ack,
    input  logic               isr_done,
    output logic               irq,
    output logic [31:0]        irq_addr,
    output logic [1:0]         active_id,
    output logic [NUM_SRC-1:0] pending,
    output logic               busy,
    output logic               ack_err
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    irq_state_e         state, state_nxt;
    logic               irq_nxt;
    logic [31:0]        addr_nxt;
    logic [ID_W-1:0]    id_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               err_nxt;
    logic               clr_en;
    logic [NUM_SRC-1:0] req_q;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] clr;
    logic               arb_vld;
    logic [ID_W-1:0]    arb_id;
    logic [ID_W-1:0]    arb_last;

    assign rise = req & ~req_q;
    assign clr  = clr_en ? (NUM_SRC'(1) << active_id) : '0;
    assign busy = (state != IDLE);

`ifdef IRQ_ROUND_ROBIN_EN
    logic [ID_W-1:0] last_q;

    // Remember the most recent grant so the next search starts just after it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= ID_W'(NUM_SRC - 1);
        end else if (state == IDLE && arb_vld) begin
            last_q <= arb_id;
        end
    end

    assign arb_last = last_q;
`else
    // Pinning the search start to id 0 turns the rotating search into lowest-id-wins.
    assign arb_last = ID_W'(NUM_SRC - 1);
`endif

    irq_arb #(
        .NUM_SRC (NUM_SRC)
    ) u_arb (
        .pending (pending),
        .mask    (mask),
        .last_id (arb_last),
        .valid   (arb_vld),
        .id      (arb_id)
    );

    // Edge-detect history and pending latch; a new edge beats an ack-clear on the same bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q   <= '0;
            pending <= '0;
        end else begin
            req_q   <= req;
            pending <= (pending & ~clr) | rise;
        end
    end

    // FSM state and the registered outputs it owns.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            irq       <= 1'b0;
            irq_addr  <= '0;
            active_id <= '0;
            cnt       <= '0;
            ack_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            irq       <= irq_nxt;
            irq_addr  <= addr_nxt;
            active_id <= id_nxt;
            cnt       <= cnt_nxt;
            ack_err   <= err_nxt;
        end
    end

    // Next-state and output decode; outputs hold unless a transition changes them.
    always_comb begin
        state_nxt = state;
        irq_nxt   = irq;
        addr_nxt  = irq_addr;
        id_nxt    = active_id;
        cnt_nxt   = cnt;
        err_nxt   = ack_err;
        clr_en    = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (arb_vld) begin
                    state_nxt = REQ;
                    irq_nxt   = 1'b1;
                    addr_nxt  = 32'(arb_id) * ISR_STRIDE;
                    id_nxt    = arb_id;
                end
            end
            REQ: begin
                if (irq_ack) begin
                    clr_en    = 1'b1;
                    irq_nxt   = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = SERVICE;
                end else if (cnt == CNT_LAST) begin
                    // Core never answered: give up, keep the source pending for a retry.
                    irq_nxt   = 1'b0;
                    err_nxt   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt   = cnt + CNT_W'(1);
                end
            end
            SERVICE: begin
                // No preemption; a non-resuming ISR parks the scheduler here.
                if (isr_done) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                irq_nxt   = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/irq_scheduler.md
IRQ_SCHEDULER -- requirements
Module: irq_scheduler

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4: number of interrupt sources.
REQ-002 SHALL have parameter ISR_STRIDE, default 32'h20: byte spacing of ISR entry points.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 15: maximum cycles to wait for irq_ack.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port req, input, NUM_SRC bits: per-source interrupt request lines.
REQ-007 SHALL have port mask, input, NUM_SRC bits: 1 = source disabled from arbitration.
REQ-008 SHALL have port irq_ack, input, 1 bit: MIPS core acceptance of the interrupt.
REQ-009 SHALL have port isr_done, input, 1 bit: ISR finished, context restored.
REQ-010 SHALL have port irq, output, 1 bit: interrupt request to the MIPS core.
REQ-011 SHALL have port irq_addr, output, 32 bits: ISR entry address, id*ISR_STRIDE.
REQ-012 SHALL have port active_id, output, 2 bits: source currently requested or in service.
REQ-013 SHALL have port pending, output, NUM_SRC bits: latched pending requests.
REQ-014 SHALL have port busy, output, 1 bit: high in REQ or SERVICE state.
REQ-015 SHALL have port ack_err, output, 1 bit: sticky flag, set on ack timeout.

Function
REQ-016 SHALL set pending[i] one cycle after a rising edge of req[i] (registered edge detect); level-held req SHALL NOT re-set it.
REQ-017 SHALL use FSM states IDLE, REQ, SERVICE.
REQ-018 IDLE: SHALL select the winner from pending & ~mask; if there is one, next cycle SHALL go to REQ with irq=1, irq_addr and active_id loaded.
REQ-019 REQ: SHALL hold irq, irq_addr and active_id stable until irq_ack=1 in REQ.
REQ-020 REQ: on irq_ack, SHALL clear pending[active_id], drop irq next cycle, and go to SERVICE.
REQ-021 SERVICE: SHALL hold irq=0 and irq_addr stable; on isr_done SHALL go to IDLE; no preemption.
REQ-022 SERVICE SHALL be held indefinitely if isr_done never arrives (non-resuming ISR).
REQ-023 SHALL ignore isr_done outside SERVICE and irq_ack outside REQ.
REQ-024 REQ: if ACK_TIMEOUT cycles pass without irq_ack, SHALL drop irq, keep pending, set ack_err, and go to IDLE.
REQ-025 A req edge and an ack-clear on the same bit in the same cycle SHALL leave pending set (set wins).
REQ-026 A source masked while in REQ SHALL NOT withdraw the in-flight request.
REQ-027 Earliest turnaround: after isr_done, next irq SHALL assert 2 cycles later.

Reset
REQ-028 On rst=0, SHALL force state IDLE, irq=0, irq_addr=0, active_id=0, pending=0, busy=0, ack_err=0, timeout counter=0, and req edge-history=0.
REQ-029 Reset mid-REQ or mid-SERVICE SHALL discard all pending and in-service state.

Configuration
REQ-030 With IRQ_ROUND_ROBIN_EN defined, arbitration SHALL be round-robin, starting search at last granted id+1 (mod NUM_SRC).
REQ-031 Without IRQ_ROUND_ROBIN_EN, arbitration SHALL be fixed priority, lowest id wins.

Structure
REQ-032 A shared package irq_pkg SHALL hold the FSM state typedef, NUM_SRC, ISR_STRIDE and ACK_TIMEOUT defaults.
REQ-033 Arbitration SHALL be one combinational sub-module, irq_arb (pending, mask, last id -> valid, id).

Verification
REQ-034 req=4'b0010, ack 1 cycle after irq -> irq_addr=32'h20, active_id=1, pending[1] cleared; isr_done -> IDLE.
REQ-035 req=4'b1100 same cycle, fixed priority -> 32'h40 served first, then 32'h60 after isr_done; with IRQ_ROUND_ROBIN_EN and last id=2 -> 32'h60 first.
REQ-036 mask=4'b0001, req[0] rises -> no irq, pending=4'b0001; mask cleared -> irq_addr=32'h0.
REQ-037 irq with no ack for 15 cycles -> irq drops, ack_err=1, pending retained; re-request follows.
REQ-038 Service id 3, never send isr_done, raise req[0] -> busy stays 1, no irq, pending[0]=1.
REQ-039 rst low during SERVICE -> all outputs 0 the same cycle, pending=0 after release.
